// File: rtl/sram_pkg.sv
// Shared types and helpers for the sram_1rw_init_ext macro family.
// SRAM_PARITY_EN adds one even-parity bit per write-mask lane.
package sram_pkg;

    typedef enum logic {
        SRAM_INIT,
        SRAM_READY
    } sram_state_e;

    // Widest lane the parity helper accepts; narrower lanes are zero-extended.
    localparam int PARITY_MAX_W = 1024;

`ifdef SRAM_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    function automatic logic lane_parity(input logic [PARITY_MAX_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/sram_1rw_core.sv
// Behavioural single-port storage array: per-lane masked write, registered read.
// Replaceable by a vendor block RAM with byte-enable writes.
module sram_1rw_core #(
    parameter int DEPTH  = 512,
    parameter int LANES  = 4,
    parameter int SLW    = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [LANES-1:0]      wmask,
    input  logic [LANES*SLW-1:0]  wdata,
    output logic [LANES*SLW-1:0]  rdata
);

    logic [LANES*SLW-1:0] mem [DEPTH];
    logic [LANES*SLW-1:0] rdata_reg;

    // No reset on the read register so the array maps onto plain block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < LANES; i++) begin
                if (wmask[i]) begin
                    mem[addr][i*SLW +: SLW] <= wdata[i*SLW +: SLW];
                end
            end
        end
        if (re) begin
            rdata_reg <= mem[addr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/sram_1rw_init_ext.sv
// Single-port masked SRAM with zero-fill sweep, ready handshake and read-valid strobe.
// Optional per-lane even parity is enabled by defining SRAM_PARITY_EN.
module sram_1rw_init_ext
    import sram_pkg::*;
#(
    parameter int DEPTH = 512,
    parameter int WIDTH = 128,
    parameter int LANES = 4
) (
    input  logic                       RW0_clk,
    input  logic                       RW0_rst_n,
    input  logic                       RW0_en,
    input  logic                       RW0_wmode,
    input  logic [$clog2(DEPTH)-1:0]   RW0_addr,
    input  logic [LANES-1:0]           RW0_wmask,
    input  logic [WIDTH-1:0]           RW0_wdata,
    input  logic                       RW0_clear,
    output logic                       RW0_ready,
    output logic [WIDTH-1:0]           RW0_rdata,
    output logic                       RW0_rvalid,
    output logic                       RW0_perr
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int LW     = WIDTH / LANES;
    localparam int SLW    = LW + PARITY_BITS;
    localparam int SW     = LANES * SLW;

    sram_state_e         state_reg;
    logic [ADDR_W-1:0]   sweep_cnt_reg;
    logic                rvalid_reg;
    logic                rd_seen_reg;

    logic                in_ready;
    logic                acc;
    logic                wr_en;
    logic                rd_en;
    logic                core_we;
    logic [ADDR_W-1:0]   core_addr;
    logic [LANES-1:0]    core_wmask;
    logic [SW-1:0]       core_wdata;
    logic [SW-1:0]       core_rdata;
    logic [WIDTH-1:0]    rd_data;
    logic                sweep_last;

    assign in_ready   = (state_reg == SRAM_READY);
    // A request coinciding with clear is dropped.
    assign acc        = in_ready & RW0_en & ~RW0_clear;
    assign wr_en      = acc & RW0_wmode;
    assign rd_en      = acc & ~RW0_wmode;
    assign sweep_last = (sweep_cnt_reg == ADDR_W'(DEPTH - 1));

    assign core_we    = ~in_ready | wr_en;
    assign core_addr  = in_ready ? RW0_addr : sweep_cnt_reg;
    assign core_wmask = in_ready ? RW0_wmask : '1;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [LW-1:0] lane_wdata;
            assign lane_wdata = in_ready ? RW0_wdata[gi*LW +: LW] : '0;
            assign core_wdata[gi*SLW +: LW] = lane_wdata;
            assign rd_data[gi*LW +: LW]     = core_rdata[gi*SLW +: LW];
`ifdef SRAM_PARITY_EN
            assign core_wdata[gi*SLW + LW] = lane_parity(PARITY_MAX_W'(lane_wdata));
`endif
        end
    endgenerate

    sram_1rw_core #(
        .DEPTH  (DEPTH),
        .LANES  (LANES),
        .SLW    (SLW),
        .ADDR_W (ADDR_W)
    ) u_core (
        .clk   (RW0_clk),
        .we    (core_we),
        .re    (rd_en),
        .addr  (core_addr),
        .wmask (core_wmask),
        .wdata (core_wdata),
        .rdata (core_rdata)
    );

    always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
        if (!RW0_rst_n) begin
            state_reg     <= SRAM_INIT;
            sweep_cnt_reg <= '0;
            rvalid_reg    <= 1'b0;
            rd_seen_reg   <= 1'b0;
        end else begin
            rvalid_reg <= rd_en;
            if (rd_en) begin
                rd_seen_reg <= 1'b1;
            end
            case (state_reg)
                SRAM_INIT: begin
                    if (RW0_clear) begin
                        sweep_cnt_reg <= '0;
                    end else if (sweep_last) begin
                        sweep_cnt_reg <= '0;
                        state_reg     <= SRAM_READY;
                    end else begin
                        sweep_cnt_reg <= sweep_cnt_reg + ADDR_W'(1);
                    end
                end
                SRAM_READY: begin
                    if (RW0_clear) begin
                        sweep_cnt_reg <= '0;
                        state_reg     <= SRAM_INIT;
                    end
                end
                default: begin
                    state_reg     <= SRAM_INIT;
                    sweep_cnt_reg <= '0;
                end
            endcase
        end
    end

    // The core read register is not reset; mask it until the first read after reset.
    assign RW0_ready  = in_ready;
    assign RW0_rvalid = rvalid_reg;
    assign RW0_rdata  = rd_seen_reg ? rd_data : '0;

`ifdef SRAM_PARITY_EN
    logic [LANES-1:0] lane_err;
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_perr
            assign lane_err[gi] = core_rdata[gi*SLW + LW]
                                ^ lane_parity(PARITY_MAX_W'(core_rdata[gi*SLW +: LW]));
        end
    endgenerate
    assign RW0_perr = rd_seen_reg & (|lane_err);
`else
    assign RW0_perr = 1'b0;
`endif

endmodule

// File: tb/tb_sram_1rw_init_ext.sv
// Directed, table-driven bench for sram_1rw_init_ext at DEPTH=16, WIDTH=128, LANES=4.
// Parity corruption checks run only when SRAM_PARITY_EN is defined.
module tb_sram_1rw_init_ext;

    localparam int DEPTH = 16;
    localparam int WIDTH = 128;
    localparam int LANES = 4;
    localparam int AW    = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic             wmode;
    logic [AW-1:0]    addr;
    logic [LANES-1:0] wmask;
    logic [WIDTH-1:0] wdata;
    logic             clear;
    logic             ready;
    logic [WIDTH-1:0] rdata;
    logic             rvalid;
    logic             perr;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sram_1rw_init_ext #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .LANES (LANES)
    ) dut (
        .RW0_clk    (clk),
        .RW0_rst_n  (rst_n),
        .RW0_en     (en),
        .RW0_wmode  (wmode),
        .RW0_addr   (addr),
        .RW0_wmask  (wmask),
        .RW0_wdata  (wdata),
        .RW0_clear  (clear),
        .RW0_ready  (ready),
        .RW0_rdata  (rdata),
        .RW0_rvalid (rvalid),
        .RW0_perr   (perr)
    );

    typedef struct {
        string            name;
        logic             en;
        logic             wmode;
        logic [AW-1:0]    addr;
        logic [LANES-1:0] wmask;
        logic [WIDTH-1:0] wdata;
        logic             clear;
        logic             exp_ready;
        logic             exp_rvalid;
        logic [WIDTH-1:0] exp_rdata;
        logic             exp_perr;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input string name, input logic e, input logic wm, input logic [AW-1:0] a,
                           input logic [LANES-1:0] m, input logic [WIDTH-1:0] d, input logic c,
                           input logic xr, input logic xv, input logic [WIDTH-1:0] xd, input logic xp);
        vec_t v;
        v.name = name; v.en = e; v.wmode = wm; v.addr = a; v.wmask = m; v.wdata = d; v.clear = c;
        v.exp_ready = xr; v.exp_rvalid = xv; v.exp_rdata = xd; v.exp_perr = xp;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        en = 1'b0; wmode = 1'b0; addr = '0; wmask = '0; wdata = '0; clear = 1'b0;
    endtask

    // Expects ready low for 15 edges then high on the 16th, with no rvalid.
    task automatic check_sweep(input string tag);
        for (int e = 1; e <= DEPTH; e++) begin
            step();
            if (e < DEPTH) begin
                chk({tag, "_ready_low"}, {127'b0, ready}, 128'd0);
            end else begin
                chk({tag, "_ready_high"}, {127'b0, ready}, 128'd1);
            end
            chk({tag, "_no_rvalid"}, {127'b0, rvalid}, 128'd0);
        end
    endtask

    task automatic read_check(input string name, input logic [AW-1:0] a,
                              input logic [WIDTH-1:0] xd, input logic xp);
        en = 1'b1; wmode = 1'b0; addr = a;
        step();
        en = 1'b0;
        chk({name, "_rvalid"}, {127'b0, rvalid}, 128'd1);
        chk({name, "_rdata"}, rdata, xd);
        chk({name, "_perr"}, {127'b0, perr}, {127'b0, xp});
    endtask

    task automatic write_word(input logic [AW-1:0] a, input logic [LANES-1:0] m, input logic [WIDTH-1:0] d);
        en = 1'b1; wmode = 1'b1; addr = a; wmask = m; wdata = d;
        step();
        idle_inputs();
    endtask

    localparam logic [WIDTH-1:0] ONES  = '1;
    localparam logic [WIDTH-1:0] A5    = 128'hA5;
    localparam logic [WIDTH-1:0] M0101 = 128'h00000000FFFFFFFF00000000FFFFFFFF;
    localparam logic [WIDTH-1:0] PAT   = 128'h44444444_33333333_22222222_11111111;
    localparam logic [WIDTH-1:0] M1010 = 128'h44444444_FFFFFFFF_22222222_FFFFFFFF;

    initial begin
        rst_n = 1'b0;
        idle_inputs();

        // Vector table: inputs held for one edge, outputs checked just after it.
        add_vec("rd5_zero",     1, 0, 5, 4'h0, '0,    0, 1, 1, '0,    0);
        add_vec("wr3_m0101",    1, 1, 3, 4'h5, ONES,  0, 1, 0, '0,    0);
        add_vec("rd3_m0101",    1, 0, 3, 4'h0, '0,    0, 1, 1, M0101, 0);
        add_vec("wr7_a5",       1, 1, 7, 4'hF, A5,    0, 1, 0, M0101, 0);
        add_vec("rd7_a5",       1, 0, 7, 4'h0, '0,    0, 1, 1, A5,    0);
        for (int i = 0; i < 5; i++) begin
            add_vec("idle_hold", 0, 0, 0, 4'h0, '0, 0, 1, 0, A5, 0);
        end
        add_vec("b2b_rd3",      1, 0, 3, 4'h0, '0,    0, 1, 1, M0101, 0);
        add_vec("b2b_rd7",      1, 0, 7, 4'h0, '0,    0, 1, 1, A5,    0);
        add_vec("wr3_m1010",    1, 1, 3, 4'hA, PAT,   0, 1, 0, A5,    0);
        add_vec("rd3_m1010",    1, 0, 3, 4'h0, '0,    0, 1, 1, M1010, 0);
        add_vec("en0_no_wr",    0, 1, 7, 4'hF, ONES,  0, 1, 0, M1010, 0);
        add_vec("rd7_unchg",    1, 0, 7, 4'h0, '0,    0, 1, 1, A5,    0);
        add_vec("clear_drops",  1, 0, 3, 4'h0, '0,    1, 0, 0, A5,    0);

        repeat (2) step();
        chk("rst_ready",  {127'b0, ready},  128'd0);
        chk("rst_rvalid", {127'b0, rvalid}, 128'd0);
        chk("rst_rdata",  rdata,            128'd0);
        chk("rst_perr",   {127'b0, perr},   128'd0);

        // Requests during the sweep must be ignored.
        rst_n = 1'b1;
        en = 1'b1; wmode = 1'b0; addr = 4'd5;
        check_sweep("sweep0");
        idle_inputs();

        foreach (vecs[i]) begin
            en = vecs[i].en; wmode = vecs[i].wmode; addr = vecs[i].addr;
            wmask = vecs[i].wmask; wdata = vecs[i].wdata; clear = vecs[i].clear;
            step();
            chk({vecs[i].name, "_ready"},  {127'b0, ready},  {127'b0, vecs[i].exp_ready});
            chk({vecs[i].name, "_rvalid"}, {127'b0, rvalid}, {127'b0, vecs[i].exp_rvalid});
            chk({vecs[i].name, "_rdata"},  rdata,            vecs[i].exp_rdata);
            chk({vecs[i].name, "_perr"},   {127'b0, perr},   {127'b0, vecs[i].exp_perr});
        end
        idle_inputs();

        // Clear was sampled at the last vector edge: 15 more low edges, then ready.
        for (int e = 1; e < DEPTH; e++) begin
            step();
            chk("clr_ready_low", {127'b0, ready}, 128'd0);
        end
        step();
        chk("clr_ready_high", {127'b0, ready}, 128'd1);
        read_check("rd7_cleared", 7, '0, 0);
        read_check("rd3_cleared", 3, '0, 0);

        // Reset in the middle of a sweep with counter at 9.
        write_word(1, 4'hF, 128'hDEAD);
        read_check("rd1_dead", 1, 128'hDEAD, 0);
        clear = 1'b1;
        step();
        clear = 1'b0;
        repeat (9) step();
        chk("mid_sweep_rdata_hold", rdata, 128'hDEAD);
        rst_n = 1'b0;
        #1;
        chk("async_rst_rdata", rdata, 128'd0);
        chk("async_rst_ready", {127'b0, ready}, 128'd0);
        step();
        rst_n = 1'b1;
        check_sweep("sweep_rst");
        read_check("rd1_swept", 1, '0, 0);

        // Clear during INIT restarts the sweep from address 0.
        clear = 1'b1;
        step();
        clear = 1'b0;
        repeat (5) step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("init_clear_ready", {127'b0, ready}, 128'd0);
        for (int e = 1; e < DEPTH; e++) begin
            step();
            chk("init_clr_ready_low", {127'b0, ready}, 128'd0);
        end
        step();
        chk("init_clr_ready_high", {127'b0, ready}, 128'd1);

`ifdef SRAM_PARITY_EN
        write_word(2, 4'hF, 128'h0123_4567_89AB_CDEF_0F1E_2D3C_4B5A_6978);
        write_word(4, 4'hF, 128'h0123_4567_89AB_CDEF_0F1E_2D3C_4B5A_6978);
        // Data bit 40 sits in lane 1, offset 8; each stored lane is 33 bits wide.
        dut.u_core.mem[2][41] = ~dut.u_core.mem[2][41];
        read_check("rd2_flipped", 2, 128'h0123_4567_89AB_CDEF_0F1E_2C3C_4B5A_6978, 1);
        read_check("rd4_clean", 4, 128'h0123_4567_89AB_CDEF_0F1E_2D3C_4B5A_6978, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_1rw_init_ext.md
# sram_1rw_init_ext

Parametrised single-port masked SRAM macro, the next generation of the fixed-geometry cache data/tag array macros. It adds a hardware zero-fill sweep after reset or on request, a ready handshake, a read-valid strobe, and read data that holds between reads instead of going undefined. It sits under the L1 cache data and tag arrays and replaces the per-geometry macros with one block.

## Interface
- DEPTH, 512, number of words; power of two, ≥ 2
- WIDTH, 128, data bits per word
- LANES, 4, write-mask lanes; WIDTH % LANES == 0; lane width LW = WIDTH/LANES
- ADDR_W, $clog2(DEPTH), address width (derived, not overridden)

Ports:
- RW0_clk  in  1  sole clock, rising edge
- RW0_rst_n  in  1  reset, asynchronous, active-low
- RW0_en  in  1  access request, sampled only while RW0_ready=1
- RW0_wmode  in  1  1 = write, 0 = read
- RW0_addr  in  ADDR_W  word address
- RW0_wmask  in  LANES  per-lane write enable; bit i covers data bits [i*LW +: LW]
- RW0_wdata  in  WIDTH  write data
- RW0_clear  in  1  start a zero-fill sweep
- RW0_ready  out  1  array accepts requests
- RW0_rdata  out  WIDTH  registered read data
- RW0_rvalid  out  1  one-cycle strobe; RW0_rdata is new this cycle
- RW0_perr  out  1  parity error on the read being returned

## Operation
- FSM states: INIT (sweep) and READY. The reset state is INIT with sweep counter = 0.
- INIT:
  - Each cycle, writes all-zero data, with zero parity, to address = counter, then increments the counter.
  - When the counter reaches DEPTH-1 and that write completes, the FSM moves to READY.
  - RW0_en is ignored. No read is performed and no rvalid is issued.
- READY:
  - With RW0_en=1 and RW0_wmode=1, each lane whose mask bit is 1 is written. Other lanes are unchanged.
  - With RW0_en=1 and RW0_wmode=0, the block reads. RW0_rdata and RW0_rvalid update on the next edge.
  - With RW0_en=0, the array and RW0_rdata are unchanged.
- RW0_clear:
  - In READY, the FSM enters INIT on the next edge with counter = 0. A request presented in the same cycle as clear is dropped.
  - In INIT, clear restarts the counter at 0.
- Reset asserted mid-sweep or mid-access: the FSM returns to INIT with counter = 0. Array contents are not reset directly; only the sweep clears them.
- RW0_rdata holds the last read value until the next read. It is cleared to 0 only by reset.
- Write followed by read of the same address on the next cycle returns the new data. The port is single, so no simultaneous read and write is possible.

## Timing
- Reset values: RW0_ready=0, RW0_rvalid=0, RW0_rdata=0, RW0_perr=0, state=INIT, counter=0.
- The sweep lasts exactly DEPTH cycles. Address k is written at rising edge k+1 after reset deassertion. RW0_ready goes high after edge DEPTH.
- Read latency is 1 cycle. A read accepted at edge n gives valid RW0_rdata, RW0_rvalid=1 and RW0_perr after edge n. RW0_rvalid drops after edge n+1 unless another read is accepted.
- Writes commit at the accepting edge. Writes have no response.
- RW0_ready drops in the cycle after RW0_clear is sampled high.
- Back-to-back reads give a new word every cycle, with RW0_rvalid held at 1.

## Configuration
- SRAM_PARITY_EN defined:
  - Each lane stores one extra even-parity bit, giving storage of WIDTH+LANES bits per word.
  - Parity is written only for lanes being written.
  - On read, RW0_perr=1 if any lane's stored parity does not match its data. It is registered alongside RW0_rdata.
- SRAM_PARITY_EN undefined: RW0_perr is tied to 0 and no parity storage exists.

## Structure
- Shared package sram_pkg:
  - state enum sram_state_e {SRAM_INIT, SRAM_READY}
  - lane-parity function
- One sub-module, sram_1rw_core: a behavioural storage array with per-lane masked write and registered read. The wrapper holds the FSM, sweep counter, muxing and parity logic. The core is swappable for vendor block RAM.

## Test plan
- DEPTH=16, WIDTH=128, LANES=4: release reset. Required: RW0_ready=0 for 16 edges and =1 after edge 16; RW0_rvalid never asserted during the sweep.
- After sweep, read address 5. Required: rvalid=1 one cycle later, rdata=0, perr=0.
- Write address 3, wmask=4'b0101, wdata all-ones; read address 3. Required: rdata=128'h00000000FFFFFFFF00000000FFFFFFFF.
- Write address 7 with wdata=128'hA5 and full mask; read it; then idle 5 cycles. Required: rdata holds 128'hA5 while rvalid=0. Then pulse RW0_clear. Required: ready=0 for 16 cycles, then a read of address 7 returns 0.
- Assert RW0_rst_n low at sweep counter 9, then release. Required: the sweep restarts at address 0 and ready rises exactly 16 edges after release.
- With SRAM_PARITY_EN: force-flip stored bit 40 of address 2, then read address 2. Required: perr=1 with rvalid. A read of an unflipped address returns perr=0.
